// File: rtl/i2si_bist_gen.sv
// BIST ramp source for the i2si input path.
// Emits a 12-bit sawtooth packed into both channels of a stereo word.
module i2si_bist_gen #(
  parameter int SAMPLE_DIV = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] rf_bist_start_val,
  input  logic [7:0]  rf_bist_inc,
  input  logic [11:0] rf_bist_up_limit,
  output logic [31:0] i2si_bist_out_data
);

  localparam int DW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(SAMPLE_DIV - 1);

  logic [DW-1:0] div_q;
  logic          strobe;
  logic [11:0]   cnt_q;
  logic [11:0]   cnt_d;
  logic [12:0]   sum;

  always_comb begin
    strobe = (div_q == DIV_LAST);
    // 13-bit sum keeps the carry so a 12-bit overflow always wraps
    sum    = {1'b0, cnt_q} + {5'b0, rf_bist_inc};
    cnt_d  = (sum > {1'b0, rf_bist_up_limit}) ? rf_bist_start_val
                                              : sum[11:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q              <= '0;
      cnt_q              <= rf_bist_start_val;
      i2si_bist_out_data <= 32'h0;
    end else begin
      div_q <= strobe ? '0 : div_q + DW'(1);
      if (strobe) begin
        i2si_bist_out_data <= {cnt_q, 4'h0, cnt_q, 4'h0};
        cnt_q              <= cnt_d;
      end
    end
  end

endmodule

// File: tb/tb_i2si_bist_gen.sv
// Bench for i2si_bist_gen: sample-level ramp model plus directed
// literal checks, for SAMPLE_DIV of 1 and 4.
module tb_i2si_bist_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [11:0] start_val = 12'h001;
  logic [7:0]  inc = 8'h01;
  logic [11:0] up_limit = 12'h019;
  logic [31:0] out1;
  logic [31:0] out4;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  i2si_bist_gen #(.SAMPLE_DIV(1)) dut1 (
    .clk(clk),
    .rst(rst),
    .rf_bist_start_val(start_val),
    .rf_bist_inc(inc),
    .rf_bist_up_limit(up_limit),
    .i2si_bist_out_data(out1)
  );

  i2si_bist_gen #(.SAMPLE_DIV(4)) dut4 (
    .clk(clk),
    .rst(rst),
    .rf_bist_start_val(start_val),
    .rf_bist_inc(inc),
    .rf_bist_up_limit(up_limit),
    .i2si_bist_out_data(out4)
  );

  function automatic logic [31:0] pack(input int s);
    logic [11:0] v;
    v = s[11:0];
    return {v, 4'h0, v, 4'h0};
  endfunction

  // Next ramp value from the plain arithmetic rule
  function automatic int ramp_next(input int c);
    int s;
    s = c + int'(inc);
    return (s > int'(up_limit)) ? int'(start_val) : s;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Model: sample index counted in clock edges since reset release
  bit          m_valid = 0;
  int          m1_cur, m4_cur, m_edges;
  logic [31:0] m1_out, m4_out;

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1;
      m_edges = 0;
      m1_cur  = int'(start_val);
      m4_cur  = int'(start_val);
      m1_out  = 32'h0;
      m4_out  = 32'h0;
    end else if (m_valid) begin
      m_edges++;
      m1_out = pack(m1_cur);
      m1_cur = ramp_next(m1_cur);
      if (m_edges % 4 == 0) begin
        m4_out = pack(m4_cur);
        m4_cur = ramp_next(m4_cur);
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_div1", out1, m1_out);
      chk("model_div4", out4, m4_out);
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("reset_out1", out1, 32'h0);
    chk("reset_out4", out4, 32'h0);
  endtask

  task automatic cfg(input logic [11:0] s, input logic [7:0] i,
                     input logic [11:0] l);
    start_val = s;
    inc       = i;
    up_limit  = l;
  endtask

  task automatic expect_seq(input string nm, input int a, input int b,
                            input int c, input int d);
    int v[4];
    v = '{a, b, c, d};
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk(nm, out1, pack(v[k]));
    end
  endtask

  initial begin
    // Basic ramp, 25-sample period
    cfg(12'h001, 8'h01, 12'h019);
    do_reset();
    for (int i = 1; i <= 26; i++) begin
      @(negedge clk);
      chk("ramp", out1, pack((i <= 25) ? i : 1));
      if (i == 3) chk("div4_hold", out4, 32'h0);
      if (i == 4) chk("div4_first", out4, 32'h00100010);
      if (i == 7) chk("div4_hold2", out4, 32'h00100010);
      if (i == 8) chk("div4_second", out4, 32'h00200020);
    end
    chk("ramp_lit_wrap", out1, 32'h00100010);

    // Exact limit, then overshoot limit
    cfg(12'h000, 8'h08, 12'h010);
    do_reset();
    expect_seq("exact_limit", 'h000, 'h008, 'h010, 'h000);
    cfg(12'h000, 8'h08, 12'h014);
    do_reset();
    expect_seq("over_limit", 'h000, 'h008, 'h010, 'h000);

    // 12-bit carry must wrap
    cfg(12'hFF0, 8'hFF, 12'hFFF);
    do_reset();
    expect_seq("carry_wrap", 'hFF0, 'hFF0, 'hFF0, 'hFF0);

    // Degenerate settings
    cfg(12'h123, 8'h00, 12'hFFF);
    do_reset();
    expect_seq("inc_zero", 'h123, 'h123, 'h123, 'h123);
    cfg(12'h100, 8'h01, 12'h050);
    do_reset();
    expect_seq("start_gt_lim", 'h100, 'h100, 'h100, 'h100);

    // Mid-run reset at sample 0x00A
    cfg(12'h001, 8'h01, 12'h019);
    do_reset();
    repeat (10) @(negedge clk);
    chk("mid_pre", out1, 32'h00A000A0);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_clear", out1, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_restart", out1, 32'h00100010);

    // Live config changes, checked by the model
    cfg(12'h000, 8'h02, 12'h020);
    do_reset();
    repeat (12) @(negedge clk);
    inc = 8'h03;
    start_val = 12'h005;
    repeat (20) @(negedge clk);
    up_limit = 12'h00C;
    repeat (20) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
